pc_fetch_unit: RTL and testbench

Program-counter register and fetch sequencer for the single-cycle MIPS core. It holds the architectural PC and drives it to the `add4` incrementer and instruction memory. It takes `PCPlus4` back and selects the next PC from sequential, branch, jump and jump-register sources. It also handles instruction-memory wait states, pipeline stall, and misaligned-target trapping.

---
 rtl/mips_pkg.sv | 17 +
 rtl/pc_fetch_unit_if.sv | 35 +++
 rtl/pc_fetch_unit_next_pc_sel.sv | 38 +++
 rtl/pc_fetch_unit.sv | 87 ++++++++
 tb/tb_pc_fetch_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch path.
// State encoding, default vectors and instruction field widths.
package mips_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        TRAP  = 2'd2
    } pc_state_t;

    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0180;

    localparam int JIDX_W = 26;
    localparam int BOFF_W = 16;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus: PC out, add4 return, redirects, imem handshake, trap.
// master is the fetch unit, slave is the surrounding core/testbench.
interface pc_fetch_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned n = 32
);
    logic [n-1:0]      pc;
    logic [n-1:0]      PCPlus4;
    logic              branch;
    logic [BOFF_W-1:0] branch_off;
    logic              jump;
    logic [JIDX_W-1:0] jump_idx;
    logic              jr;
    logic [n-1:0]      jr_target;
    logic              stall;
    logic              imem_req;
    logic              imem_ready;
    logic              trap;
    logic              trap_ack;
    logic [n-1:0]      epc;
    logic [31:0]       fetch_count;

    modport master (
        output pc, imem_req, trap, epc, fetch_count,
        input  PCPlus4, branch, branch_off, jump, jump_idx,
        input  jr, jr_target, stall, imem_ready, trap_ack
    );

    modport slave (
        input  pc, imem_req, trap, epc, fetch_count,
        output PCPlus4, branch, branch_off, jump, jump_idx,
        output jr, jr_target, stall, imem_ready, trap_ack
    );
endinterface

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Next-PC target mux: jr > jump > branch > sequential.
// Flags targets whose low two bits are not zero.
module next_pc_sel
    import mips_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic [n-1:0]      PCPlus4,
    input  logic              branch,
    input  logic [BOFF_W-1:0] branch_off,
    input  logic              jump,
    input  logic [JIDX_W-1:0] jump_idx,
    input  logic              jr,
    input  logic [n-1:0]      jr_target,
    output logic [n-1:0]      target,
    output logic              misaligned
);
    logic [n-1:0] br_ofs;
    logic [n-1:0] br_tgt;
    logic [n-1:0] j_tgt;

    // Word offset: sign-extend then scale by 4
    assign br_ofs = {{(n-BOFF_W-2){branch_off[BOFF_W-1]}}, branch_off, 2'b00};
    assign br_tgt = PCPlus4 + br_ofs;
    assign j_tgt  = {PCPlus4[n-1:JIDX_W+2], jump_idx, 2'b00};

    always_comb begin
        target = PCPlus4;
        priority case (1'b1)
            jr:      target = jr_target;
            jump:    target = j_tgt;
            branch:  target = br_tgt;
            default: target = PCPlus4;
        endcase
    end

    assign misaligned = |target[1:0];
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer: BOOT -> FETCH, misaligned JR traps.
// add4 is external; PCPlus4 returns combinationally on the bus.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned  n         = 32,
    parameter logic [n-1:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [n-1:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic            clk,
    input  logic            rst,
    pc_fetch_unit_if.master bus
);
    pc_state_t    state_q;
    logic [n-1:0] pc_q;
    logic [n-1:0] epc_q;
    logic [31:0]  cnt_q;
    logic         req_q;
    logic         trap_q;
    logic [n-1:0] pc_d;
    logic         misal;
    logic         adv;

    next_pc_sel #(.n(n)) u_sel (
        .PCPlus4    (bus.PCPlus4),
        .branch     (bus.branch),
        .branch_off (bus.branch_off),
        .jump       (bus.jump),
        .jump_idx   (bus.jump_idx),
        .jr         (bus.jr),
        .jr_target  (bus.jr_target),
        .target     (pc_d),
        .misaligned (misal)
    );

    assign adv = bus.imem_ready & ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            trap_q  <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: begin
                    if (adv) begin
                        if (misal) begin
                            epc_q   <= pc_q;
                            pc_q    <= EXC_VEC;
                            trap_q  <= 1'b1;
                            req_q   <= 1'b0;
                            state_q <= TRAP;
                        end else begin
                            pc_q  <= pc_d;
                            cnt_q <= cnt_q + 32'd1;
                        end
                    end
                end
                TRAP: begin
                    if (bus.trap_ack) begin
                        trap_q  <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    req_q   <= 1'b0;
                    trap_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.trap        = trap_q;
    assign bus.epc         = epc_q;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a behavioural add4.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_ok  = 0;

    pc_fetch_unit_if #(.n(32)) bus ();

    pc_fetch_unit #(.n(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.PCPlus4 = bus.pc + 32'd4;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_ok++;
        else $display("FAIL %s: got %08h want %08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_redir();
        bus.jr     = 1'b0;
        bus.jump   = 1'b0;
        bus.branch = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.branch     = 1'b0;
        bus.branch_off = '0;
        bus.jump       = 1'b0;
        bus.jump_idx   = '0;
        bus.jr         = 1'b0;
        bus.jr_target  = '0;
        bus.stall      = 1'b0;
        bus.imem_ready = 1'b1;
        bus.trap_ack   = 1'b0;
        tick();
        tick();
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_cnt", bus.fetch_count, 32'd0);

        // boot cycle then first fetch at RESET_VEC
        rst = 1'b0;
        chk("boot_pc", bus.pc, 32'h0);
        chk("boot_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("f0_pc", bus.pc, 32'h0);
        chk("f0_req", 32'(bus.imem_req), 32'd1);
        tick();
        chk("f1_pc", bus.pc, 32'h4);
        tick();
        chk("f2_pc", bus.pc, 32'h8);
        tick();
        chk("f3_pc", bus.pc, 32'hC);
        chk("f3_cnt", bus.fetch_count, 32'd3);
        tick();
        chk("f4_pc", bus.pc, 32'h10);

        // wait states then stall
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_pc", bus.pc, 32'h10);
        end
        bus.imem_ready = 1'b1;
        bus.stall      = 1'b1;
        tick();
        chk("stall_pc", bus.pc, 32'h10);
        chk("stall_cnt", bus.fetch_count, 32'd4);
        bus.stall = 1'b0;
        tick();
        chk("resume_pc", bus.pc, 32'h14);
        chk("resume_cnt", bus.fetch_count, 32'd5);

        // redirects
        bus.jr = 1'b1; bus.jr_target = 32'h100;
        tick();
        chk("jr_pc", bus.pc, 32'h100);
        clr_redir();
        bus.branch = 1'b1; bus.branch_off = 16'hFFFF;
        tick();
        chk("br_neg_pc", bus.pc, 32'h100);
        clr_redir();
        bus.jump = 1'b1; bus.jump_idx = 26'h40;
        tick();
        chk("j_pc", bus.pc, 32'h100);
        bus.jr = 1'b1; bus.jump = 1'b1; bus.branch = 1'b1;
        bus.jr_target = 32'h2000;
        tick();
        chk("prio_pc", bus.pc, 32'h2000);
        clr_redir();
        bus.jump = 1'b1; bus.branch = 1'b1; bus.branch_off = 16'h0010;
        bus.jump_idx = 26'h80;
        tick();
        chk("j_over_br", bus.pc, 32'h200);
        clr_redir();
        bus.branch = 1'b1; bus.branch_off = 16'h0003;
        tick();
        chk("br_pos_pc", bus.pc, 32'h210);
        clr_redir();
        chk("redir_cnt", bus.fetch_count, 32'd11);

        // misaligned JR
        bus.jr = 1'b1; bus.jr_target = 32'h200;
        tick();
        chk("pre_trap_pc", bus.pc, 32'h200);
        bus.jr_target = 32'h2002;
        tick();
        chk("trap_set", 32'(bus.trap), 32'd1);
        chk("trap_epc", bus.epc, 32'h200);
        chk("trap_pc", bus.pc, 32'h8000_0180);
        chk("trap_req", 32'(bus.imem_req), 32'd0);
        chk("trap_cnt", bus.fetch_count, 32'd12);
        bus.jr_target = 32'h3001;
        bus.stall     = 1'b1;
        tick();
        chk("trap_hold", 32'(bus.trap), 32'd1);
        chk("trap_hold_pc", bus.pc, 32'h8000_0180);
        chk("trap_hold_epc", bus.epc, 32'h200);
        clr_redir();
        bus.stall    = 1'b0;
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        chk("ack_trap", 32'(bus.trap), 32'd0);
        chk("ack_req", 32'(bus.imem_req), 32'd1);
        chk("ack_pc", bus.pc, 32'h8000_0180);
        tick();
        chk("exc_adv_pc", bus.pc, 32'h8000_0184);
        chk("exc_adv_cnt", bus.fetch_count, 32'd13);
        chk("epc_kept", bus.epc, 32'h200);

        // wrap-around
        bus.jr = 1'b1; bus.jr_target = 32'hFFFF_FFFC;
        tick();
        clr_redir();
        chk("top_pc", bus.pc, 32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", bus.pc, 32'h0);
        tick();
        chk("post_wrap_pc", bus.pc, 32'h4);

        // reset while trapped
        bus.jr = 1'b1; bus.jr_target = 32'h3;
        tick();
        clr_redir();
        chk("trap2_set", 32'(bus.trap), 32'd1);
        chk("trap2_epc", bus.epc, 32'h4);
        rst = 1'b1;
        tick();
        chk("rt_trap", 32'(bus.trap), 32'd0);
        chk("rt_epc", bus.epc, 32'h0);
        chk("rt_pc", bus.pc, 32'h0);
        chk("rt_req", 32'(bus.imem_req), 32'd0);
        chk("rt_cnt", bus.fetch_count, 32'd0);
        rst = 1'b0;
        chk("rt_boot_req", 32'(bus.imem_req), 32'd0);
        tick();
        chk("rt_fetch_req", 32'(bus.imem_req), 32'd1);
        chk("rt_fetch_pc", bus.pc, 32'h0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
